// File: rtl/risc_ctrl_seq_if.sv
// Datapath strobe bundle between the RISC instruction sequencer (master) and
// the datapath/IR decode it controls (slave).
interface risc_ctrl_seq_if #(
  parameter int OPCODE_W = 3,
  parameter int ICNT_W   = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                rd;
  logic                wr;
  logic                ld_ir;
  logic                ld_ac;
  logic                ld_pc;
  logic                inc_pc;
  logic                data_e;
  logic                halt;
  logic [2:0]          phase;
  logic [ICNT_W-1:0]   instr_cnt;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase, instr_cnt
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase, instr_cnt
  );
endinterface

// File: rtl/risc_ctrl_seq.sv
// Eight-phase instruction sequencer for the accumulator RISC CPU.
// Optional single-step gating of phase 0 is enabled by defining RISC_CTRL_STEP_EN.
module risc_ctrl_seq #(
  parameter int OPCODE_W = 3,
  parameter int ICNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef RISC_CTRL_STEP_EN
  input  logic step,
`endif
  risc_ctrl_seq_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);
  localparam logic [ICNT_W-1:0]   CNT_MAX = {ICNT_W{1'b1}};

  phase_e            phase_q, phase_d;
  logic              halt_q, halt_d;
  logic [ICNT_W-1:0] cnt_q, cnt_d;
  logic              adv_s;
  logic [2:0]        phase_inc_s;
  logic              aluop_s, is_skz_s, is_sto_s, is_jmp_s;
  logic              sel_s, rd_s, wr_s, ld_ir_s, ld_ac_s, ld_pc_s, inc_pc_s, data_e_s;

  assign phase_inc_s = phase_q + 3'd1;
  assign aluop_s     = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                       (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign is_skz_s    = (bus.opcode == OP_SKZ);
  assign is_sto_s    = (bus.opcode == OP_STO);
  assign is_jmp_s    = (bus.opcode == OP_JMP);

  // Next phase, halt latch and saturating retire count.
  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    adv_s   = ~halt_q;
`ifdef RISC_CTRL_STEP_EN
    if ((phase_q == INST_ADDR) && !step) begin
      adv_s = 1'b0;
    end else begin
      adv_s = ~halt_q;
    end
`endif
    if (adv_s) begin
      if ((phase_q == OP_ADDR) && (bus.opcode == OP_HLT)) begin
        // HLT parks in OP_FETCH, whose decode is already silent for non-ALU ops
        halt_d  = 1'b1;
        phase_d = OP_FETCH;
      end else begin
        phase_d = phase_e'(phase_inc_s);
        if ((phase_q == STORE) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + ICNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
      cnt_q   <= {ICNT_W{1'b0}};
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath strobe decode from phase, opcode and zero flag.
  always_comb begin
    sel_s    = 1'b0;
    rd_s     = 1'b0;
    wr_s     = 1'b0;
    ld_ir_s  = 1'b0;
    ld_ac_s  = 1'b0;
    ld_pc_s  = 1'b0;
    inc_pc_s = 1'b0;
    data_e_s = 1'b0;
    if (halt_q) begin
      sel_s = 1'b0;
    end else begin
      case (phase_q)
        INST_ADDR:  sel_s = 1'b1;
        INST_FETCH: begin
          sel_s = 1'b1;
          rd_s  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel_s   = 1'b1;
          rd_s    = 1'b1;
          ld_ir_s = 1'b1;
        end
        OP_ADDR:    inc_pc_s = 1'b1;
        OP_FETCH:   rd_s = aluop_s;
        ALU_OP: begin
          rd_s     = aluop_s;
          inc_pc_s = is_skz_s & bus.zero;
          ld_pc_s  = is_jmp_s;
          data_e_s = is_sto_s;
        end
        STORE: begin
          rd_s     = aluop_s;
          ld_ac_s  = aluop_s;
          inc_pc_s = is_jmp_s;
          ld_pc_s  = is_jmp_s;
          wr_s     = is_sto_s;
          data_e_s = is_sto_s;
        end
        default: sel_s = 1'b0;
      endcase
    end
  end

  assign bus.sel       = sel_s;
  assign bus.rd        = rd_s;
  assign bus.wr        = wr_s;
  assign bus.ld_ir     = ld_ir_s;
  assign bus.ld_ac     = ld_ac_s;
  assign bus.ld_pc     = ld_pc_s;
  assign bus.inc_pc    = inc_pc_s;
  assign bus.data_e    = data_e_s;
  assign bus.halt      = halt_q;
  assign bus.phase     = phase_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Randomized self-checking bench for risc_ctrl_seq against an instruction-level
// reference model; exercises RISC_CTRL_STEP_EN when that macro is defined.
module tb_risc_ctrl_seq;
  localparam int CW = 5;  // narrow counter so saturation is reachable

  logic clk;
  logic rst;
  logic step;
  int   n_checks;
  int   n_errors;

  // reference model state
  int   m_phase;
  bit   m_halt;
  int   m_cnt;

  risc_ctrl_seq_if #(.OPCODE_W(3), .ICNT_W(CW)) bus ();

  risc_ctrl_seq #(.OPCODE_W(3), .ICNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef RISC_CTRL_STEP_EN
    .step (step),
`endif
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e} from the instruction-level rules
  function automatic logic [7:0] exp_strobes(int ph, bit hl, logic [2:0] op, logic z);
    bit alu, sto, jmp, skz;
    alu = (op >= 3'd2) && (op <= 3'd5);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    if (hl) return 8'd0;
    return {ph < 4,
            (ph >= 1 && ph <= 3) || (ph >= 5 && alu),
            ph == 7 && sto,
            ph == 2 || ph == 3,
            ph == 7 && alu,
            ph >= 6 && jmp,
            ph == 4 || (ph == 6 && skz && z == 1'b1) || (ph == 7 && jmp),
            ph >= 6 && sto};
  endfunction

  task automatic check_all();
    logic [7:0] got;
    got = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.data_e};
    check_val("strobes", 32'(got), 32'(exp_strobes(m_phase, m_halt, bus.opcode, bus.zero)));
    check_val("phase", 32'(bus.phase), 32'(m_phase));
    check_val("halt", 32'(bus.halt), 32'(m_halt));
    check_val("instr_cnt", 32'(bus.instr_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_halt  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_advance();
    bit go;
    go = !m_halt;
`ifdef RISC_CTRL_STEP_EN
    if (m_phase == 0 && step == 1'b0) go = 1'b0;
`endif
    if (go) begin
      if (m_phase == 4 && bus.opcode == 3'd0) begin
        m_halt  = 1'b1;
        m_phase = 5;
      end else begin
        if (m_phase == 7 && m_cnt < (1 << CW) - 1) m_cnt++;
        m_phase = (m_phase + 1) % 8;
      end
    end
  endtask

  // One clock: drive inputs, check mid-cycle, advance model, land just after the edge.
  task automatic run_cycle(input logic [2:0] op, input logic z);
    bus.opcode = op;
    bus.zero   = z;
    @(negedge clk);
    check_all();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // One instruction: opcode scrambled during fetch phases, held from phase 4 on.
  task automatic run_instr(input logic [2:0] op, input logic z);
    for (int k = 0; k < 8; k++) begin
      if (m_phase < 4) run_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else run_cycle(op, z);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    step       = 1'b1;
    bus.opcode = 3'd2;
    bus.zero   = 1'b0;
    rst        = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // directed instructions
    run_instr(3'd2, 1'b0);  // ADD
    check_val("cnt_after_first", 32'(bus.instr_cnt), 32'd1);
    run_instr(3'd6, 1'b0);  // STO
    run_instr(3'd1, 1'b1);  // SKZ taken
    run_instr(3'd1, 1'b0);  // SKZ not taken
    run_instr(3'd7, 1'b1);  // JMP
    run_instr(3'd5, 1'b1);  // LDA

    // random non-HLT instructions, long enough to saturate the counter
    for (int i = 0; i < 45; i++) begin
      run_instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    end
    check_val("cnt_saturated", 32'(bus.instr_cnt), 32'((1 << CW) - 1));

    // program with HLT as third instruction
    apply_reset();
    run_instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    run_instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    run_instr(3'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      run_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    check_val("halt_cnt", 32'(bus.instr_cnt), 32'd2);
    check_val("halt_phase", 32'(bus.phase), 32'd5);

    // asynchronous reset mid-cycle while halted
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // mid-instruction reset from a random phase
    run_instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < int'($urandom_range(1, 7)); i++) run_cycle(3'd2, 1'b0);
    apply_reset();
    run_instr(3'd3, 1'b0);

`ifdef RISC_CTRL_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 20; i++) run_cycle(3'($urandom_range(0, 7)), 1'b0);
    check_val("step_hold_phase", 32'(bus.phase), 32'd0);
    step = 1'b1;
    run_cycle(3'd2, 1'b0);
    step = 1'b0;
    for (int i = 0; i < 12; i++) run_cycle(3'd4, 1'b0);
    check_val("step_one_instr", 32'(bus.phase), 32'd0);
    step = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
